uart_n: RTL

Parametrised full-duplex UART, the successor to the fixed 8N1 Uart8.
- Configurable data width, parity mode, stop-bit count and baud rate.
- 16x-oversampled receiver with start-glitch rejection.
- Separate framing-error and parity-error reporting.
- Sits between on-board logic and the serial pins; two instances can be cross-wired tx->rx for loopback.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_n.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM states and the
// baud divider calculation.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} txState_e;

  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
  } rxState_e;

  // Rounded clock divider giving `oversample` ticks per bit.
  function automatic int unsigned calcDiv(input int unsigned clockRate,
                                          input int unsigned baudRate,
                                          input int unsigned oversample);
    return (clockRate + (oversample * baudRate) / 2) / (oversample * baudRate);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-clk tick every DIV clks; `clear` restarts the
// period so the first tick lands exactly DIV clks later.
module uart_baud_gen #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cntQ;

  // Period counter, wraps at DIV-1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cntQ <= '0;
    end else if (cntQ == LAST) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntQ + W'(1);
    end
  end

  assign tick = (cntQ == LAST);

endmodule

// File: rtl/uart_n.sv
// Parametrised full-duplex UART: independent transmitter and 16x-oversampled receiver.
module uart_n
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxEn,
  input  logic                 rx,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParityErr,
  output logic [DATA_BITS-1:0] out,
  input  logic                 txEn,
  input  logic                 txStart,
  input  logic [DATA_BITS-1:0] in,
  output logic                 txBusy,
  output logic                 txDone,
  output logic                 tx
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_n: DATA_BITS must be in 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : gBadParity
    $error("uart_n: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("uart_n: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned TX_DIV = calcDiv(CLOCK_RATE, BAUD_RATE, 1);
  localparam int unsigned RX_DIV = calcDiv(CLOCK_RATE, BAUD_RATE, 16);
  localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic ODD        = (PARITY == PARITY_ODD);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  txState_e             txStateQ, txStateD;
  logic [DATA_BITS-1:0] txShiftQ, txShiftD;
  logic [3:0]           txCntQ, txCntD;
  logic                 txParQ, txParD, txLineQ, txLineD;
  logic                 txBusyQ, txBusyD, txDoneQ, txDoneD, txStartQ;
  logic                 txTick, txAccept;

  assign txAccept = txEn && (txStateQ == TxIdle) && txStart && !txStartQ;

  uart_baud_gen #(.DIV(TX_DIV)) uTxBaud (.clk(clk), .rst(rst), .clear(txAccept), .tick(txTick));

  // TX next state; the line value is registered so tx changes on the clk after a decision.
  always_comb begin
    txStateD = txStateQ;
    txShiftD = txShiftQ;
    txCntD   = txCntQ;
    txParD   = txParQ;
    txLineD  = txLineQ;
    txBusyD  = txBusyQ;
    txDoneD  = 1'b0;
    if (!txEn) begin
      txStateD = TxIdle;
      txLineD  = 1'b1;
      txBusyD  = 1'b0;
    end else begin
      unique case (txStateQ)
        TxIdle: if (txAccept) begin
          txStateD = TxStart;
          txShiftD = in;
          txParD   = (^in) ^ ODD;
          txLineD  = 1'b0;
          txBusyD  = 1'b1;
        end
        TxStart: if (txTick) begin
          txStateD = TxData;
          txLineD  = txShiftQ[0];
          txCntD   = '0;
        end
        TxData: if (txTick) begin
          if (txCntQ == LAST_DATA) begin
            txCntD = '0;
            if (HAS_PARITY) begin
              txStateD = TxParity;
              txLineD  = txParQ;
            end else begin
              txStateD = TxStop;
              txLineD  = 1'b1;
            end
          end else begin
            txShiftD = txShiftQ >> 1;
            txLineD  = txShiftQ[1];
            txCntD   = txCntQ + 4'd1;
          end
        end
        TxParity: if (txTick) begin
          txStateD = TxStop;
          txLineD  = 1'b1;
        end
        TxStop: if (txTick) begin
          if (txCntQ == LAST_STOP) begin
            txStateD = TxIdle;
            txBusyD  = 1'b0;
            txDoneD  = 1'b1;
          end else begin
            txCntD = txCntQ + 4'd1;
          end
        end
        default: txStateD = TxIdle;
      endcase
    end
  end

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      txStateQ <= TxIdle;
      txShiftQ <= '0;
      txCntQ   <= '0;
      txParQ   <= 1'b0;
      txLineQ  <= 1'b1;
      txBusyQ  <= 1'b0;
      txDoneQ  <= 1'b0;
      txStartQ <= 1'b0;
    end else begin
      txStateQ <= txStateD;
      txShiftQ <= txShiftD;
      txCntQ   <= txCntD;
      txParQ   <= txParD;
      txLineQ  <= txLineD;
      txBusyQ  <= txBusyD;
      txDoneQ  <= txDoneD;
      txStartQ <= txStart;
    end
  end

  assign tx     = txLineQ;
  assign txBusy = txBusyQ;
  assign txDone = txDoneQ;

  // ---------------- receiver ----------------
  rxState_e             rxStateQ, rxStateD;
  logic [DATA_BITS-1:0] rxShiftQ, rxShiftD, outQ, outD;
  logic [3:0]           rxTickCntQ, rxTickCntD, rxBitCntQ, rxBitCntD;
  logic                 rxMetaQ, rxSyncQ, rxPrevQ;
  logic                 rxParAccQ, rxParAccD, rxStopBadQ, rxStopBadD;
  logic                 rxBusyQ, rxBusyD, rxDoneQ, rxDoneD;
  logic                 rxErrQ, rxErrD, rxParityErrQ, rxParityErrD;
  logic                 rxTick, rxFall, rxClear, rxSample, rxParBad;

  assign rxFall   = rxPrevQ && !rxSyncQ;
  assign rxClear  = rxEn && (rxStateQ == RxIdle) && rxFall;
  // Start bit is checked at tick 8 (mid-bit); every later bit 16 ticks after that.
  assign rxSample = rxTick && ((rxStateQ == RxStart) ? (rxTickCntQ == 4'd7)
                                                     : (rxTickCntQ == 4'd15));
  assign rxParBad = HAS_PARITY && (rxParAccQ ^ ODD);

  uart_baud_gen #(.DIV(RX_DIV)) uRxBaud (.clk(clk), .rst(rst), .clear(rxClear), .tick(rxTick));

  // RX next state, sampling and end-of-frame reporting.
  always_comb begin
    rxStateD     = rxStateQ;
    rxShiftD     = rxShiftQ;
    rxTickCntD   = rxTickCntQ;
    rxBitCntD    = rxBitCntQ;
    rxParAccD    = rxParAccQ;
    rxStopBadD   = rxStopBadQ;
    rxBusyD      = rxBusyQ;
    outD         = outQ;
    rxDoneD      = 1'b0;
    rxErrD       = 1'b0;
    rxParityErrD = 1'b0;
    if (rxTick) rxTickCntD = rxTickCntQ + 4'd1;
    if (rxSample) rxTickCntD = '0;
    if (!rxEn) begin
      rxStateD = RxIdle;
      rxBusyD  = 1'b0;
    end else begin
      unique case (rxStateQ)
        RxIdle: if (rxFall) begin
          rxStateD   = RxStart;
          rxBusyD    = 1'b1;
          rxTickCntD = '0;
        end
        RxStart: if (rxSample) begin
          if (rxSyncQ) begin
            rxStateD = RxIdle;
            rxBusyD  = 1'b0;
          end else begin
            rxStateD   = RxData;
            rxBitCntD  = '0;
            rxParAccD  = 1'b0;
            rxStopBadD = 1'b0;
          end
        end
        RxData: if (rxSample) begin
          rxShiftD  = {rxSyncQ, rxShiftQ[DATA_BITS-1:1]};
          rxParAccD = rxParAccQ ^ rxSyncQ;
          if (rxBitCntQ == LAST_DATA) begin
            rxBitCntD = '0;
            rxStateD  = HAS_PARITY ? RxParity : RxStop;
          end else begin
            rxBitCntD = rxBitCntQ + 4'd1;
          end
        end
        RxParity: if (rxSample) begin
          rxParAccD = rxParAccQ ^ rxSyncQ;
          rxStateD  = RxStop;
        end
        RxStop: if (rxSample) begin
          rxStopBadD = rxStopBadQ | !rxSyncQ;
          if (rxBitCntQ == LAST_STOP) begin
            rxBusyD = 1'b0;
            if (rxStopBadD) begin
              rxErrD       = 1'b1;
              rxParityErrD = rxParBad;
              rxStateD     = RxWaitHigh;
            end else begin
              outD         = rxShiftQ;
              rxParityErrD = rxParBad;
              rxDoneD      = !rxParBad;
              rxStateD     = RxIdle;
            end
          end else begin
            rxBitCntD = rxBitCntQ + 4'd1;
          end
        end
        // A held-low line (break) must go high before another frame can start.
        RxWaitHigh: if (rxSyncQ) rxStateD = RxIdle;
        default: rxStateD = RxIdle;
      endcase
    end
  end

  // RX synchroniser and state register; synchroniser resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMetaQ      <= 1'b1;
      rxSyncQ      <= 1'b1;
      rxPrevQ      <= 1'b1;
      rxStateQ     <= RxIdle;
      rxShiftQ     <= '0;
      rxTickCntQ   <= '0;
      rxBitCntQ    <= '0;
      rxParAccQ    <= 1'b0;
      rxStopBadQ   <= 1'b0;
      rxBusyQ      <= 1'b0;
      outQ         <= '0;
      rxDoneQ      <= 1'b0;
      rxErrQ       <= 1'b0;
      rxParityErrQ <= 1'b0;
    end else begin
      rxMetaQ      <= rx;
      rxSyncQ      <= rxMetaQ;
      rxPrevQ      <= rxSyncQ;
      rxStateQ     <= rxStateD;
      rxShiftQ     <= rxShiftD;
      rxTickCntQ   <= rxTickCntD;
      rxBitCntQ    <= rxBitCntD;
      rxParAccQ    <= rxParAccD;
      rxStopBadQ   <= rxStopBadD;
      rxBusyQ      <= rxBusyD;
      outQ         <= outD;
      rxDoneQ      <= rxDoneD;
      rxErrQ       <= rxErrD;
      rxParityErrQ <= rxParityErrD;
    end
  end

  assign rxBusy      = rxBusyQ;
  assign rxDone      = rxDoneQ;
  assign rxErr       = rxErrQ;
  assign rxParityErr = rxParityErrQ;
  assign out         = outQ;

endmodule
